// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states and loader command bytes.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0] CMD_IMEM = 8'h00;
    localparam logic [7:0] CMD_DMEM = 8'h01;
    localparam logic [7:0] CMD_GO   = 8'hFF;

    // True for the two command bytes that open a memory section.
    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == CMD_IMEM) || (b == CMD_DMEM);
    endfunction

endpackage

// File: rtl/boot_ctrl_word_assembler.sv
// Collects little-endian bytes into DATA_W-bit words and pulses word_valid
// for one cycle once the last byte of a word has been taken.
module word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;

    // New bytes enter at the top so the first byte ends up in the low lane.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (byte_valid) begin
            shift_d = (shift_q >> 8) | (DATA_W'(byte_data) << (DATA_W - 8));
            if (cnt_q == LAST_BYTE) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Byte count and pulse are cleared by reset so a partial word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = shift_q;

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: parses a byte stream of memory sections into imem/dmem
// word writes, then releases the CPU from reset for a bounded run.
module boot_ctrl
    import boot_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 8,
    parameter int unsigned RUN_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err
);

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    boot_state_e       state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       left_q, left_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [31:0]       run_cnt_q, run_cnt_d;

    logic              accept;
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic [15:0]       len_word;
    logic [32:0]       len_ext;

    word_assembler #(
        .DATA_W(DATA_W)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(accept && (state_q == ST_DATA)),
        .byte_data (in_data),
        .word_valid(word_valid),
        .word_data (word_data)
    );

    assign in_ready = ((state_q == ST_CMD) || (state_q == ST_LEN0) ||
                       (state_q == ST_LEN1) || (state_q == ST_DATA)) && !word_valid;
    assign accept   = in_valid && in_ready;
    assign len_word = {in_data, len_lo_q};
    assign len_ext  = {17'd0, len_word};

    assign mem_we    = word_valid;
    assign mem_sel   = sel_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_data;
    assign cpu_rstn  = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);

    // Section parser, word counter and run budget; DONE and ERR only leave on reset.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        left_d    = left_q;
        len_lo_d  = len_lo_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            ST_CMD: begin
                if (accept) begin
                    if (is_load_cmd(in_data)) begin
                        sel_d   = in_data[0];
                        addr_d  = '0;
                        state_d = ST_LEN0;
                    end else if (in_data == CMD_GO) begin
                        run_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    left_d = len_word;
                    if (len_word == 16'd0) begin
                        state_d = ST_CMD;
                    end else if (len_ext > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    left_d = left_q - 16'd1;
                    if (left_q == 16'd1) begin
                        state_d = ST_CMD;
                    end
                end
            end
            ST_RUN: begin
                if (RUN_CYCLES != 0) begin
                    if (run_cnt_q == 32'(RUN_CYCLES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        run_cnt_d = run_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // State and counters; reset aborts any section or run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CMD;
            sel_q     <= 1'b0;
            addr_q    <= '0;
            left_q    <= '0;
            len_lo_q  <= '0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            left_q    <= left_d;
            len_lo_q  <= len_lo_d;
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: streams are parsed by a byte-level model into the list
// of writes they must produce; a monitor checks every strobe and invariant.
module tb_boot_ctrl;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int RUN_CYCLES = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rstn;
    logic              done;
    logic              err;

    boot_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RUN_CYCLES(RUN_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_sel  (mem_sel),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rstn (cpu_rstn),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expW[$];
    logic [7:0]  stream[$];
    int          passCount = 0;
    int          totalCount = 0;
    int          writeTotal = 0;
    int          runTotal = 0;
    int          writeBase = 0;
    int          runBase = 0;
    int          consumed = 0;
    bit          expErr = 1'b0;
    bit          expGo = 1'b0;
    bit          prevWe = 1'b0;
    logic [31:0] dutMem[2][256];
    logic [31:0] modelMem[2][256];
    bit          modelHit[2][256];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        totalCount++;
        if (actual === required) passCount++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
                      name, actual, required, $time);
    endtask

    // Per-cycle monitor: every write strobe against the expected list, plus invariants.
    always @(negedge clk) begin
        int idx;
        if (!rst) begin
            if (mem_we) begin
                idx = writeTotal - writeBase;
                checkOutput("we_not_ready", 32'(in_ready), 32'd0);
                checkOutput("we_single_cycle", 32'(prevWe), 32'd0);
                if (idx < expW.size()) begin
                    checkOutput("wr_sel", 32'(mem_sel), 32'(expW[idx].sel));
                    checkOutput("wr_addr", 32'(mem_addr), 32'(expW[idx].addr));
                    checkOutput("wr_data", mem_wdata, expW[idx].data);
                end else begin
                    totalCount++;
                    $display("[TB] FAIL wr_unexpected: write #%0d sel=%0d addr=0x%0h, required no write",
                             idx, mem_sel, mem_addr);
                end
                dutMem[mem_sel][mem_addr] = mem_wdata;
                writeTotal++;
            end
            if (cpu_rstn) runTotal++;
            if (err) begin
                checkOutput("err_in_ready", 32'(in_ready), 32'd0);
                checkOutput("err_cpu_rstn", 32'(cpu_rstn), 32'd0);
                checkOutput("err_mem_we", 32'(mem_we), 32'd0);
            end
            if (done) checkOutput("done_cpu_rstn", 32'(cpu_rstn), 32'd0);
            prevWe = mem_we;
        end
    end

    // Walk the stream by the section rules and list every write it implies.
    task automatic parseStream();
        int pos;
        int n;
        logic [7:0] cmd;
        wr_t w;
        pos = 0;
        expW.delete();
        expErr = 1'b0;
        expGo = 1'b0;
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 256; a++) begin
                modelHit[t][a] = 1'b0;
                modelMem[t][a] = '0;
                dutMem[t][a] = 'x;
            end
        end
        while (pos < stream.size()) begin
            cmd = stream[pos];
            pos++;
            if (cmd == 8'h00 || cmd == 8'h01) begin
                if (pos + 2 > stream.size()) break;
                n = int'(stream[pos]) + 256 * int'(stream[pos+1]);
                pos += 2;
                if (n > (1 << ADDR_W)) begin
                    expErr = 1'b1;
                    break;
                end
                for (int k = 0; k < n; k++) begin
                    if (pos + 4 > stream.size()) break;
                    w.sel = cmd[0];
                    w.addr = k[7:0];
                    w.data = {stream[pos+3], stream[pos+2], stream[pos+1], stream[pos]};
                    pos += 4;
                    expW.push_back(w);
                    modelMem[w.sel][w.addr] = w.data;
                    modelHit[w.sel][w.addr] = 1'b1;
                end
            end else if (cmd == 8'hFF) begin
                expGo = 1'b1;
                break;
            end else begin
                expErr = 1'b1;
                break;
            end
        end
        consumed = pos;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gapMax);
        int gaps;
        int waited;
        gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            totalCount++;
            $display("[TB] FAIL handshake_timeout: in_ready=0 for byte 0x%0h, required 1", b);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
    endtask

    // Send the parsed stream and compare final status and memory image with the model.
    task automatic runScenario(input int gapMax);
        int t;
        parseStream();
        writeBase = writeTotal;
        runBase = runTotal;
        for (int i = 0; i < consumed; i++) applyStimulus(stream[i], gapMax);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (expGo) begin
            t = 0;
            while (!done && t < 3 * RUN_CYCLES + 20) begin
                @(negedge clk);
                t++;
            end
            checkOutput("run_cycles", 32'(runTotal - runBase), 32'(RUN_CYCLES));
        end
        checkOutput("write_count", 32'(writeTotal - writeBase), 32'(expW.size()));
        checkOutput("err_flag", 32'(err), 32'(expErr));
        checkOutput("done_flag", 32'(done), 32'(expGo));
        checkOutput("idle_in_ready", 32'(in_ready), 32'(!expErr && !expGo));
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                if (modelHit[s][a]) checkOutput("mem_image", dutMem[s][a], modelMem[s][a]);
    endtask

    task automatic buildRandomStream();
        int nsec;
        int r;
        int n;
        stream.delete();
        nsec = int'($urandom_range(3, 1));
        for (int s = 0; s < nsec; s++) begin
            r = int'($urandom_range(99, 0));
            if (r < 5) begin
                stream.push_back(8'($urandom_range(254, 2)));
            end else begin
                stream.push_back(8'(r % 2));
                n = (r < 10) ? 0 : ((r < 13) ? 257 : int'($urandom_range(4, 1)));
                stream.push_back(n[7:0]);
                stream.push_back(n[15:8]);
                if (n <= 256)
                    for (int k = 0; k < 4 * n; k++) stream.push_back(8'($urandom));
            end
        end
        if ($urandom_range(1, 0) == 1) stream.push_back(8'hFF);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        doReset();
        checkResetState();

        // Two imem words
        stream = '{8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        runScenario(0);
        checkOutput("imem0_literal", dutMem[0][0], 32'h00000013);
        checkOutput("imem1_literal", dutMem[0][1], 32'h00100093);
        checkOutput("imem_writes_literal", 32'(writeTotal - writeBase), 32'd2);

        // dmem word then go
        stream = '{8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF};
        runScenario(0);
        checkOutput("dmem0_literal", dutMem[1][0], 32'h12345678);
        checkOutput("run_literal", 32'(runTotal - runBase), 32'd20);
        checkOutput("done_literal", 32'(done), 32'd1);
        checkOutput("done_rstn_literal", 32'(cpu_rstn), 32'd0);

        // Reset out of DONE
        doReset();
        checkResetState();

        // Bad command byte
        stream = '{8'h42};
        parseStream();
        writeBase = writeTotal;
        applyStimulus(8'h42, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bad_cmd_err_next", 32'(err), 32'd1);
        checkOutput("bad_cmd_in_ready", 32'(in_ready), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("bad_cmd_in_ready_later", 32'(in_ready), 32'd0);
        checkOutput("bad_cmd_no_writes", 32'(writeTotal - writeBase), 32'd0);

        // Count too large
        doReset();
        stream = '{8'h00, 8'h01, 8'h01};
        runScenario(0);
        checkOutput("len_0101_err", 32'(err), 32'd1);

        // Zero count returns to CMD; following section still works
        doReset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        runScenario(0);
        checkOutput("zero_len_err", 32'(err), 32'd0);
        checkOutput("after_zero_dmem", dutMem[1][0], 32'hDDCCBBAA);

        // Full 256-word section
        doReset();
        stream = '{8'h00, 8'h00, 8'h01};
        for (int k = 0; k < 1024; k++) stream.push_back(8'($urandom));
        runScenario(0);
        checkOutput("full_section_writes", 32'(writeTotal - writeBase), 32'd256);

        // Reset after half a word
        doReset();
        stream = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        parseStream();
        writeBase = writeTotal;
        for (int i = 0; i < 5; i++) applyStimulus(stream[i], 0);
        @(negedge clk);
        in_valid = 1'b0;
        doReset();
        repeat (3) @(negedge clk);
        checkOutput("abort_no_write", 32'(writeTotal - writeBase), 32'd0);
        checkResetState();
        stream = '{8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        runScenario(0);
        checkOutput("abort_next_word_addr0", dutMem[0][0], 32'h11223344);

        // Same two-word stream with random gaps
        for (int rep = 0; rep < 3; rep++) begin
            doReset();
            stream = '{8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                       8'h93, 8'h00, 8'h10, 8'h00};
            runScenario(3);
            checkOutput("gap_imem0", dutMem[0][0], 32'h00000013);
            checkOutput("gap_imem1", dutMem[0][1], 32'h00100093);
        end

        // Random streams against the model
        for (int it = 0; it < 20; it++) begin
            doReset();
            buildRandomStream();
            runScenario(int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
